// File: rtl/bp_be_fe_roll_queue.sv
// -----------------------------------------------------------------------------
// bp_be_fe_roll_queue
//
// Replayable FIFO between the front-end fetch path and the BE issue scheduler.
// Fetch/exception messages are written at the tail. They are handed to the
// scheduler with a valid/yumi handshake. Every issued entry stays in storage
// until the scheduler commits it. A roll (cache-miss replay) rewinds the issue
// pointer to the oldest uncommitted entry. A commit (deq) frees the oldest
// issued entry. A redirect (clr_v_i) discards every entry that has not been
// issued yet.
//
// Pointers (ptr_width_lp bits each; the MSB is the wrap bit, the rest the index):
//   wptr : next slot to write
//   rptr : next entry to issue
//   cptr : oldest uncommitted entry
//   cptr <= rptr <= wptr holds modulo 2*els_p.
//
// Handshakes:
//   Enqueue : the message transfers on a cycle where fe_queue_v_i and
//             fe_queue_ready_o are both high. A valid that is not ready is
//             held off and has no effect.
//   Issue   : fe_queue_yumi_i may only be raised while fe_queue_v_o is high.
//             It consumes fe_queue_o in that same cycle.
//   Commit  : fe_queue_deq_i may only be raised while at least one issued
//             entry is uncommitted (rptr != cptr).
//   Illegal yumi or deq is flagged by a simulation assertion. It does not
//   move any pointer.
//
// Optional feature, selected by the macro BP_BE_FE_ROLL_QUEUE_BYPASS_EN:
//   When the queue has nothing to issue and a message is accepted, that message
//   is presented on fe_queue_o in the same cycle (0-cycle latency). It is still
//   written to storage. A same-cycle yumi advances rptr together with wptr, so
//   the entry remains replayable. Without the macro the latency is 1 cycle.
//
// Ports:
//   clk_i             in   sole clock, rising edge
//   reset_i           in   synchronous active-high reset
//   clr_v_i           in   redirect flush of unissued entries
//   fe_queue_i        in   message from the front end
//   fe_queue_v_i      in   enqueue valid
//   fe_queue_ready_o  out  enqueue ready
//   fe_queue_o        out  entry at the read pointer (or bypassed input)
//   fe_queue_v_o      out  an unissued entry is available
//   fe_queue_yumi_i   in   scheduler consumes fe_queue_o
//   fe_queue_roll_i   in   replay: rewind rptr to cptr
//   fe_queue_deq_i    in   commit the oldest issued entry
//   debug_wptr        out  write pointer state
//   debug_rptr        out  read pointer state
//   debug_cptr        out  commit pointer state
//
// fe_queue_width_lp stands in for the configuration-derived message width
// (vaddr_width_p / branch_metadata_fwd_width_p of the processor config).
// -----------------------------------------------------------------------------
module bp_be_fe_roll_queue #(
  parameter int els_p             = 8,
  parameter int fe_queue_width_lp = 32,
  localparam int idx_width_lp     = $clog2(els_p),
  localparam int ptr_width_lp     = idx_width_lp + 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clr_v_i,

  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,

  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_yumi_i,

  input  logic                         fe_queue_roll_i,
  input  logic                         fe_queue_deq_i,

  output logic [ptr_width_lp-1:0]      debug_wptr,
  output logic [ptr_width_lp-1:0]      debug_rptr,
  output logic [ptr_width_lp-1:0]      debug_cptr
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [fe_queue_width_lp-1:0] mem [els_p];

  logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;

  logic [idx_width_lp-1:0] widx, ridx, cidx;
  assign widx = wptr_r[ptr_width_lp-2:0];
  assign ridx = rptr_r[ptr_width_lp-2:0];
  assign cidx = cptr_r[ptr_width_lp-2:0];

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  logic full, empty_rd, issued_any;
  logic enq_fire, yumi_fire, deq_fire, bypass;

  // Full when the write and commit pointers have the same index but sit on
  // different laps, i.e. els_p entries are held between them.
  assign full       = (widx == cidx) && (wptr_r[ptr_width_lp-1] != cptr_r[ptr_width_lp-1]);
  assign empty_rd   = (rptr_r == wptr_r);
  assign issued_any = (rptr_r != cptr_r);

  assign fe_queue_ready_o = ~reset_i & ~full & ~clr_v_i;
  assign enq_fire         = fe_queue_v_i & fe_queue_ready_o;

`ifdef BP_BE_FE_ROLL_QUEUE_BYPASS_EN
  // Nothing is waiting to issue, so the incoming message is the next in order.
  assign bypass = empty_rd & enq_fire;
`else
  assign bypass = 1'b0;
`endif

  // A roll cycle never issues. The rewound entry appears on the next cycle.
  assign fe_queue_v_o = (~empty_rd | bypass) & ~clr_v_i & ~fe_queue_roll_i;
  assign fe_queue_o   = bypass ? fe_queue_i : mem[ridx];

  // Illegal requests are masked here so they can never corrupt the pointers.
  assign yumi_fire = fe_queue_yumi_i & fe_queue_v_o;
  assign deq_fire  = fe_queue_deq_i & issued_any;

  // ---------------------------------------------------------------------------
  // Next-pointer logic
  //   cptr first (commit), then rptr (roll beats yumi, roll lands on the
  //   post-commit cptr), then wptr (a flush trims back to the post-roll rptr).
  // ---------------------------------------------------------------------------
  always_comb begin
    cptr_n = cptr_r;
    rptr_n = rptr_r;
    wptr_n = wptr_r;

    if (deq_fire) begin
      cptr_n = cptr_r + ptr_width_lp'(1);
    end

    if (fe_queue_roll_i) begin
      rptr_n = cptr_n;
    end else if (yumi_fire) begin
      rptr_n = rptr_r + ptr_width_lp'(1);
    end

    // ready is low during a flush, so enqueue and flush never coincide.
    if (clr_v_i) begin
      wptr_n = rptr_n;
    end else if (enq_fire) begin
      wptr_n = wptr_r + ptr_width_lp'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  // Storage is not reset. Only slots between cptr and wptr are ever read.
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      mem[widx] <= fe_queue_i;
    end
  end

  assign debug_wptr = wptr_r;
  assign debug_rptr = rptr_r;
  assign debug_cptr = cptr_r;

  // ---------------------------------------------------------------------------
  // Protocol assertions (simulation only)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      yumi_legal: assert (!(fe_queue_yumi_i && !fe_queue_v_o));
      deq_legal:  assert (!(fe_queue_deq_i && !issued_any));
    end
  end

endmodule

// File: tb/tb_bp_be_fe_roll_queue.sv
`timescale 1ns/1ps
module tb_bp_be_fe_roll_queue;

  localparam int W   = 32;
  localparam int ELS = 8;
`ifdef BP_BE_FE_ROLL_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr = 1'b0, v_in = 1'b0, yumi = 1'b0, roll = 1'b0, deq = 1'b0;
  logic [W-1:0] fe_in = '0;
  logic ready, v_out;
  logic [W-1:0] fe_out;
  logic [3:0] dw, dr, dc;

  always #5 clk = ~clk;

  bp_be_fe_roll_queue #(.els_p(ELS), .fe_queue_width_lp(W)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .clr_v_i          (clr),
    .fe_queue_i       (fe_in),
    .fe_queue_v_i     (v_in),
    .fe_queue_ready_o (ready),
    .fe_queue_o       (fe_out),
    .fe_queue_v_o     (v_out),
    .fe_queue_yumi_i  (yumi),
    .fe_queue_roll_i  (roll),
    .fe_queue_deq_i   (deq),
    .debug_wptr       (dw),
    .debug_rptr       (dr),
    .debug_cptr       (dc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Reference model: exp_q holds all uncommitted messages, oldest first.
  // The first n_iss of them have been issued. c_tot counts commits.
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int n_iss = 0;
  int c_tot = 0;

  function automatic bit m_empty();
    return n_iss == exp_q.size();
  endfunction
  function automatic bit m_ready();
    return !reset && (exp_q.size() != ELS) && !clr;
  endfunction
  function automatic bit m_bypass();
    return BYP && m_empty() && v_in && m_ready();
  endfunction
  function automatic bit m_v();
    return (!m_empty() || m_bypass()) && !clr && !roll;
  endfunction
  function automatic logic [W-1:0] m_data();
    return m_bypass() ? fe_in : exp_q[n_iss];
  endfunction

  task automatic expect_eq(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    expect_eq("ready", W'(ready), W'(m_ready()));
    expect_eq("v_o", W'(v_out), W'(m_v()));
    if (m_v()) expect_eq("data", fe_out, m_data());
    expect_eq("wptr", W'(dw), W'((c_tot + exp_q.size()) % (2*ELS)));
    expect_eq("rptr", W'(dr), W'((c_tot + n_iss) % (2*ELS)));
    expect_eq("cptr", W'(dc), W'(c_tot % (2*ELS)));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(bit r, bit c, bit v, logic [W-1:0] d, bit y, bit rl, bit dq, bit chk);
    @(negedge clk);
    reset = r; clr = c; v_in = v; fe_in = d; yumi = y; roll = rl; deq = dq;
    #1;
    if (chk) check_model();
  endtask

  // Advance one edge and update the model from the inputs held this cycle.
  task automatic tick();
    bit r_s, c_s, rl_s, enq, y_ok, d_ok;
    logic [W-1:0] d_s;
    r_s = reset; c_s = clr; rl_s = roll; d_s = fe_in;
    enq  = v_in && m_ready();
    y_ok = yumi && m_v();
    d_ok = deq && (n_iss > 0);
    @(posedge clk);
    if (r_s) begin
      exp_q.delete();
      n_iss = 0;
      c_tot = 0;
    end else begin
      if (enq) exp_q.push_back(d_s);
      if (d_ok) begin
        void'(exp_q.pop_front());
        n_iss--;
        c_tot++;
      end
      if (rl_s) n_iss = 0;
      else if (y_ok) n_iss++;
      if (c_s) while (exp_q.size() > n_iss) void'(exp_q.pop_back());
    end
  endtask

  task automatic step(bit r, bit c, bit v, logic [W-1:0] d, bit y, bit rl, bit dq);
    drive(r, c, v, d, y, rl, dq, 1'b1);
    tick();
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: {inputs, expected outputs} per cycle
  // ---------------------------------------------------------------------------
  typedef struct {
    bit r, c, v;
    logic [W-1:0] d;
    bit y, rl, dq;
    bit e_ready, e_v;
    logic [W-1:0] e_data;
    logic [3:0] e_w, e_r, e_c;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(bit r, bit c, bit v, logic [W-1:0] d, bit y, bit rl, bit dq,
                              bit er, bit ev, logic [W-1:0] ed,
                              logic [3:0] ew, logic [3:0] erp, logic [3:0] ec);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.d = d; t.y = y; t.rl = rl; t.dq = dq;
    t.e_ready = er; t.e_v = ev; t.e_data = ed; t.e_w = ew; t.e_r = erp; t.e_c = ec;
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  localparam logic [W-1:0] A = 32'hA000_0001;
  localparam logic [W-1:0] B = 32'hB000_0002;
  localparam logic [W-1:0] C = 32'hC000_0003;
  localparam logic [W-1:0] D = 32'hD000_0004;

  initial begin
    // Enqueue A,B,C; issue them in order; commit all three.
    tbl[0]  = mk(1,0,0,'0,0,0,0, 0,0,  '0, 0,0,0);
    tbl[1]  = mk(0,0,1, A,0,0,0, 1,BYP, A, 0,0,0);
    tbl[2]  = mk(0,0,1, B,0,0,0, 1,1,   A, 1,0,0);
    tbl[3]  = mk(0,0,1, C,0,0,0, 1,1,   A, 2,0,0);
    tbl[4]  = mk(0,0,0,'0,1,0,0, 1,1,   A, 3,0,0);
    tbl[5]  = mk(0,0,0,'0,1,0,0, 1,1,   B, 3,1,0);
    tbl[6]  = mk(0,0,0,'0,1,0,0, 1,1,   C, 3,2,0);
    tbl[7]  = mk(0,0,0,'0,0,0,1, 1,0,  '0, 3,3,0);
    tbl[8]  = mk(0,0,0,'0,0,0,1, 1,0,  '0, 3,3,1);
    tbl[9]  = mk(0,0,0,'0,0,0,1, 1,0,  '0, 3,3,2);
    tbl[10] = mk(0,0,0,'0,0,0,0, 1,0,  '0, 3,3,3);

    @(posedge clk);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].y, tbl[i].rl, tbl[i].dq, 1'b0);
      expect_eq($sformatf("tbl%0d_ready", i), W'(ready), W'(tbl[i].e_ready));
      expect_eq($sformatf("tbl%0d_v", i), W'(v_out), W'(tbl[i].e_v));
      if (tbl[i].e_v) expect_eq($sformatf("tbl%0d_data", i), fe_out, tbl[i].e_data);
      expect_eq($sformatf("tbl%0d_wptr", i), W'(dw), W'(tbl[i].e_w));
      expect_eq($sformatf("tbl%0d_rptr", i), W'(dr), W'(tbl[i].e_r));
      expect_eq($sformatf("tbl%0d_cptr", i), W'(dc), W'(tbl[i].e_c));
      tick();
    end

    // Fill to capacity; a 9th valid is refused; yumi + deq reopens ready.
    do_reset();
    for (int i = 0; i < ELS; i++) step(0, 0, 1, W'(32'h100 + i), 0, 0, 0);
    drive(0, 0, 0, '0, 0, 0, 0, 1'b1);
    expect_eq("full_ready_low", W'(ready), W'(0));
    tick();
    step(0, 0, 1, 32'h1FF, 0, 0, 0);
    drive(0, 0, 0, '0, 0, 0, 0, 1'b1);
    expect_eq("full_9th_refused", W'(dw), W'(8));
    tick();
    step(0, 0, 0, '0, 1, 0, 0);
    step(0, 0, 0, '0, 0, 0, 1);
    drive(0, 0, 0, '0, 0, 0, 0, 1'b1);
    expect_eq("ready_after_deq", W'(ready), W'(1));
    tick();

    // Issue A,B,C, commit A, roll: B,C,D replay.
    do_reset();
    step(0, 0, 1, A, 0, 0, 0);
    step(0, 0, 1, B, 0, 0, 0);
    step(0, 0, 1, C, 0, 0, 0);
    step(0, 0, 1, D, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1, 0, 0);
    step(0, 0, 0, '0, 0, 0, 1);
    step(0, 0, 0, '0, 0, 1, 0);
    drive(0, 0, 0, '0, 1, 0, 0, 1'b1);
    expect_eq("roll_first_B", fe_out, B);
    expect_eq("roll_cptr", W'(dc), W'(1));
    tick();
    drive(0, 0, 0, '0, 1, 0, 0, 1'b1);
    expect_eq("roll_then_C", fe_out, C);
    tick();
    drive(0, 0, 0, '0, 1, 0, 0, 1'b1);
    expect_eq("roll_then_D", fe_out, D);
    tick();

    // Flush after issuing A,B: unissued C,D vanish; roll replays A,B only.
    do_reset();
    step(0, 0, 1, A, 0, 0, 0);
    step(0, 0, 1, B, 0, 0, 0);
    step(0, 0, 1, C, 0, 0, 0);
    step(0, 0, 1, D, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    step(0, 1, 0, '0, 0, 0, 0);
    drive(0, 0, 0, '0, 0, 0, 0, 1'b1);
    expect_eq("clr_v_low", W'(v_out), W'(0));
    expect_eq("clr_wptr", W'(dw), W'(2));
    expect_eq("clr_rptr", W'(dr), W'(2));
    tick();
    step(0, 0, 0, '0, 0, 1, 0);
    drive(0, 0, 0, '0, 1, 0, 0, 1'b1);
    expect_eq("clr_replay_A", fe_out, A);
    tick();
    drive(0, 0, 0, '0, 1, 0, 0, 1'b1);
    expect_eq("clr_replay_B", fe_out, B);
    tick();
    drive(0, 0, 0, '0, 0, 0, 0, 1'b1);
    expect_eq("clr_replay_end", W'(v_out), W'(0));
    tick();

    // Same-cycle deq + roll with A,B issued.
    do_reset();
    step(0, 0, 1, A, 0, 0, 0);
    step(0, 0, 1, B, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    step(0, 0, 0, '0, 0, 1, 1);
    drive(0, 0, 0, '0, 0, 0, 0, 1'b1);
    expect_eq("deqroll_rptr", W'(dr), W'(1));
    expect_eq("deqroll_cptr", W'(dc), W'(1));
    expect_eq("deqroll_data_B", fe_out, B);
    tick();

    // 20 enqueue/yumi/deq rounds walk every pointer across the wrap.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, $urandom, 0, 0, 0);
      step(0, 0, 0, '0, 1, 0, 0);
      step(0, 0, 0, '0, 0, 0, 1);
    end

`ifdef BP_BE_FE_ROLL_QUEUE_BYPASS_EN
    // Bypass: enqueue into empty with a same-cycle yumi.
    do_reset();
    drive(0, 0, 1, 32'h5A5A_0001, 1, 0, 0, 1'b1);
    expect_eq("bypass_data", fe_out, 32'h5A5A_0001);
    expect_eq("bypass_v", W'(v_out), W'(1));
    tick();
    drive(0, 0, 0, '0, 0, 0, 0, 1'b1);
    expect_eq("bypass_wptr", W'(dw), W'(1));
    expect_eq("bypass_rptr", W'(dr), W'(1));
    tick();
`endif

    // Randomised legal traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      clr   = ($urandom_range(0, 24) == 0);
      roll  = ($urandom_range(0, 14) == 0);
      v_in  = ($urandom_range(0, 2) != 0);
      fe_in = $urandom;
      deq   = (n_iss > 0) && ($urandom_range(0, 2) == 0);
      yumi  = 1'b0;
      yumi  = m_v() && ($urandom_range(0, 1) == 1);
      #1;
      check_model();
      tick();
    end

    @(negedge clk);
    reset = 1'b0; clr = 1'b0; v_in = 1'b0; yumi = 1'b0; roll = 1'b0; deq = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
